// File: rtl/csla_pkg.sv
// Shared definitions for the carry-select accumulator.
// Holds the datapath width, the default counter widths and the FSM state enum.
package csla_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned OVF_W_DEF  = 8;
    localparam int unsigned BEAT_W_DEF = 16;

    // Ripple width of each carry-select block inside the adder
    localparam int unsigned CSEL_BLK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/csla_64bit.sv
// 64-bit carry-select adder: {cout, sum} = a + b + cin.
// Ports:
//   a, b  : DATA_W-bit operands
//   cin   : carry-in
//   sum   : DATA_W-bit result (modulo 2^DATA_W)
//   cout  : carry-out of the full-width add
// Each block precomputes its result for both possible incoming carries;
// the real carry then only steers a mux per block.
module csla_64bit
    import csla_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    localparam int unsigned NBLK = DATA_W / CSEL_BLK_W;

    logic [NBLK:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [CSEL_BLK_W:0] s0;
        logic [CSEL_BLK_W:0] s1;

        // Speculative block sums for incoming carry 0 and 1
        assign s0 = (CSEL_BLK_W+1)'(a[g*CSEL_BLK_W +: CSEL_BLK_W])
                  + (CSEL_BLK_W+1)'(b[g*CSEL_BLK_W +: CSEL_BLK_W]);
        assign s1 = (CSEL_BLK_W+1)'(a[g*CSEL_BLK_W +: CSEL_BLK_W])
                  + (CSEL_BLK_W+1)'(b[g*CSEL_BLK_W +: CSEL_BLK_W])
                  + (CSEL_BLK_W+1)'(1);

        assign sum[g*CSEL_BLK_W +: CSEL_BLK_W] = carry[g] ? s1[CSEL_BLK_W-1:0]
                                                          : s0[CSEL_BLK_W-1:0];
        assign carry[g+1] = carry[g] ? s1[CSEL_BLK_W] : s0[CSEL_BLK_W];
    end

    assign cout = carry[NBLK];

endmodule

// File: rtl/csla_accum_64.sv
// Packetised 64-bit accumulator built around one carry-select adder.
// Beats are summed (with per-beat carry-in) until in_last; the result is then
// held on the output until out_ready, with in_ready low for the whole hold.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_cin/in_last : operand beat stream
//   out_valid/out_ready                      : result handshake
//   out_sum       : accumulated sum
//   out_ovf_cnt   : beats whose add carried out (saturating)
//   out_beats     : beats accepted in the packet (saturating)
// Build option: define CSLA_ACCUM_SAT_EN to saturate the sum to all-ones on
// the first carry-out of a packet instead of wrapping.
module csla_accum_64
    import csla_pkg::*;
#(
    parameter int unsigned OVF_W  = OVF_W_DEF,
    parameter int unsigned BEAT_W = BEAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    input  logic              in_cin,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_sum,
    output logic [OVF_W-1:0]  out_ovf_cnt,
    output logic [BEAT_W-1:0] out_beats
);

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] a_op;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              accept_c;
    logic              first_c;

    logic [DATA_W-1:0] acc_nxt;
    logic [OVF_W-1:0]  ovf_base;
    logic [OVF_W-1:0]  ovf_nxt;
    logic [BEAT_W-1:0] beats_base;
    logic [BEAT_W-1:0] beats_nxt;

    assign accept_c = in_valid && in_ready;
    // A beat taken in IDLE starts a fresh packet: no residue from before
    assign first_c  = (state == IDLE);
    assign a_op     = first_c ? '0 : acc;
    assign out_sum  = acc;

    csla_64bit u_add (
        .a    (a_op),
        .b    (in_data),
        .cin  (in_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register plus the handshake flags decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != HOLD);
            out_valid <= (state_nxt == HOLD);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept_c && in_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating counter updates; base is zero for the first beat of a packet
    always_comb begin
        ovf_base   = first_c ? '0 : out_ovf_cnt;
        beats_base = first_c ? '0 : out_beats;
        ovf_nxt    = ovf_base;
        beats_nxt  = beats_base;
        if (add_cout && (ovf_base != '1)) begin
            ovf_nxt = ovf_base + OVF_W'(1);
        end
        if (beats_base != '1) begin
            beats_nxt = beats_base + BEAT_W'(1);
        end
    end

`ifdef CSLA_ACCUM_SAT_EN
    logic sat;
    logic sat_nxt;

    // Sticky per-packet saturation: once a carry is seen the sum pins to all-ones
    always_comb begin
        sat_nxt = (first_c ? 1'b0 : sat) | add_cout;
        acc_nxt = sat_nxt ? '1 : add_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat <= 1'b0;
        end else if (accept_c) begin
            sat <= sat_nxt;
        end
    end
`else
    assign acc_nxt = add_sum;
`endif

    // Datapath registers only move on an accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            out_ovf_cnt <= '0;
            out_beats   <= '0;
        end else if (accept_c) begin
            acc         <= acc_nxt;
            out_ovf_cnt <= ovf_nxt;
            out_beats   <= beats_nxt;
        end
    end

endmodule

// File: tb/tb_csla_accum_64.sv
// Directed bench for csla_accum_64: table of packets plus hand sequences for
// back-pressure, reset mid-packet/in hold and counter saturation.
module tb_csla_accum_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_cin;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic [7:0]  out_ovf_cnt;
    logic [15:0] out_beats;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    csla_accum_64 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_cin      (in_cin),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_ovf_cnt (out_ovf_cnt),
        .out_beats   (out_beats)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       nb;
        logic [2:0][63:0] data;
        logic [2:0]       cin;
        logic [63:0]      exp_sum;
        logic [7:0]       exp_ovf;
        logic [15:0]      exp_beats;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] nb,
                                input logic [63:0] d0, input logic c0,
                                input logic [63:0] d1, input logic c1,
                                input logic [63:0] d2, input logic c2,
                                input logic [63:0] es, input logic [7:0] eo,
                                input logic [15:0] eb);
        vec_t v;
        v.nb        = nb;
        v.data[0]   = d0;
        v.data[1]   = d1;
        v.data[2]   = d2;
        v.cin       = {c2, c1, c0};
        v.exp_sum   = es;
        v.exp_ovf   = eo;
        v.exp_beats = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one beat on the falling edge; it transfers on the following rising edge
    task automatic beat(input logic [63:0] d, input logic c, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        in_last  = l;
    endtask

    // Check the held result one cycle after the last beat, then release it
    task automatic result(input string name, input logic [63:0] es,
                          input logic [7:0] eo, input logic [15:0] eb);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({name, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({name, ".in_ready"},  64'(in_ready),  64'd0);
        chk({name, ".sum"},       out_sum,        es);
        chk({name, ".ovf"},       64'(out_ovf_cnt), 64'(eo));
        chk({name, ".beats"},     64'(out_beats),   64'(eb));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".idle_valid"}, 64'(out_valid), 64'd0);
        chk({name, ".idle_ready"}, 64'(in_ready),  64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [63:0] e_wrap2;
        logic [63:0] e_ff3;
        logic [63:0] e_ff1;
`ifdef CSLA_ACCUM_SAT_EN
        e_wrap2 = ONES;
        e_ff3   = ONES;
        e_ff1   = ONES;
`else
        e_wrap2 = 64'd1;
        e_ff3   = 64'd0;
        e_ff1   = 64'd0;
`endif
        vecs[0] = mk(2'd1, 64'd45, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd45, 8'd0, 16'd1);
        vecs[1] = mk(2'd3, 64'd10, 1'b0, 64'd35, 1'b0, 64'd23, 1'b1, 64'd69, 8'd0, 16'd3);
        vecs[2] = mk(2'd2, ONES, 1'b0, 64'd2, 1'b0, 64'd0, 1'b0, e_wrap2, 8'd1, 16'd2);
        vecs[3] = mk(2'd2, 64'd6223372036854775808, 1'b1, 64'd38701384792384, 1'b0,
                     64'd0, 1'b0, 64'd6223410738239568193, 8'd0, 16'd2);
        vecs[4] = mk(2'd3, ONES, 1'b1, ONES, 1'b1, ONES, 1'b1, e_ff3, 8'd3, 16'd3);
        vecs[5] = mk(2'd1, ONES, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, e_ff1, 8'd1, 16'd1);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cin    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        chk("reset.sum",       out_sum,        64'd0);
        chk("reset.ovf",       64'(out_ovf_cnt), 64'd0);
        chk("reset.beats",     64'(out_beats),   64'd0);

        // Table-driven packets
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < int'(vecs[i].nb); b++) begin
                beat(vecs[i].data[b], vecs[i].cin[b], (b == int'(vecs[i].nb) - 1));
            end
            result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_ovf, vecs[i].exp_beats);
        end

        // Back-pressure: result holds, data 99 offered but never taken
        beat(64'd500, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'd99;
        in_cin   = 1'b0;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d.valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d.ready", k), 64'(in_ready),  64'd0);
            chk($sformatf("hold%0d.sum", k),   out_sum,        64'd500);
            chk($sformatf("hold%0d.beats", k), 64'(out_beats), 64'd1);
            @(negedge clk);
        end
        chk("hold_end.ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk("hold_rel.valid", 64'(out_valid), 64'd0);
        chk("hold_rel.ready", 64'(in_ready),  64'd1);
        beat(64'd1, 1'b0, 1'b1);
        result("after_hold", 64'd1, 8'd0, 16'd1);

        // Reset mid-packet discards the partial sum
        beat(64'd5, 1'b0, 1'b0);
        beat(64'd6, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.valid", 64'(out_valid), 64'd0);
        chk("midrst.ready", 64'(in_ready),  64'd1);
        chk("midrst.sum",   out_sum,        64'd0);
        chk("midrst.beats", 64'(out_beats), 64'd0);
        beat(64'd7, 1'b0, 1'b1);
        result("post_rst", 64'd7, 8'd0, 16'd1);

        // Reset while holding a result
        beat(64'd8, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hrst.pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("hrst.valid", 64'(out_valid), 64'd0);
        chk("hrst.ready", 64'(in_ready),  64'd1);
        chk("hrst.sum",   out_sum,        64'd0);

        // Overflow counter saturates at 255 over 300 carrying beats
        for (int b = 0; b < 300; b++) begin
            beat(ONES, 1'b1, (b == 299));
        end
        result("ovf_sat", e_ff3, 8'd255, 16'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
